// File: rtl/hdr_loader_pkg.sv
// Shared types and helpers for the header loader.
// Optional statistics counters are enabled in hdr_loader by HDR_LOADER_STATS_EN.
package hdr_loader_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } hdr_loader_state_t;

  localparam int BYTE_W = 8;

  // Keep is MSB-contiguous, so the popcount is also the number of leading valid lanes.
  function automatic logic [2:0] keep_cnt(input logic [3:0] keep);
    return 3'(keep[0]) + 3'(keep[1]) + 3'(keep[2]) + 3'(keep[3]);
  endfunction

endpackage

// File: rtl/hdr_loader.sv
// Assembles a big-endian 32-bit word stream into a zero-padded header buffer and hands it to proc.
// Define HDR_LOADER_STATS_EN to add packet and truncation counters.
module hdr_loader
  import hdr_loader_pkg::*;
#(
  parameter int HDR_MAX_LEN = 64,
  parameter int LEN_W       = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [31:0]                   s_data_i,
  input  logic [3:0]                    s_keep_i,
  input  logic                          s_last_i,
  output logic [BYTE_W*HDR_MAX_LEN-1:0] pkt_hdr_o,
  output logic [LEN_W-1:0]              hdr_len_o,
  output logic                          trunc_o,
  output logic                          start_o,
`ifdef HDR_LOADER_STATS_EN
  output logic [31:0]                   pkt_cnt_o,
  output logic [31:0]                   trunc_cnt_o,
`endif
  input  logic                          ready_i
);

  localparam logic [LEN_W:0] MAX_P = (LEN_W+1)'(HDR_MAX_LEN);

  hdr_loader_state_t             state_q, state_d;
  logic [LEN_W:0]                wr_ptr_q, wr_ptr_d;
  logic [BYTE_W*HDR_MAX_LEN-1:0] hdr_q, hdr_d;
  logic                          trunc_q, trunc_d;
  logic                          first_q, first_d;

  logic [7:0]     lane [4];
  logic [2:0]     cnt;
  logic [LEN_W:0] base;
  logic [LEN_W:0] sum;
  logic           xfer;

  always_comb begin
    for (int k = 0; k < 4; k++) lane[k] = s_data_i[8*(3-k) +: 8];
  end

  assign s_ready_o = (state_q == FILL) || (state_q == DRAIN);
  assign start_o   = (state_q == START) || (state_q == RUN);
  assign xfer      = s_valid_i && s_ready_o;
  assign cnt       = keep_cnt(s_keep_i);
  // A new packet writes from offset 0; wr_ptr_q still shows the previous length until then.
  assign base      = first_q ? '0 : wr_ptr_q;
  assign sum       = base + (LEN_W+1)'(cnt);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    hdr_d    = hdr_q;
    trunc_d  = trunc_q;
    first_d  = first_q;
    unique case (state_q)
      FILL: begin
        if (xfer && cnt != 3'd0) begin
          first_d = 1'b0;
          if (first_q) begin
            hdr_d   = '0;
            trunc_d = 1'b0;
          end
          for (int i = 0; i < HDR_MAX_LEN; i++) begin
            if ((LEN_W+1)'(i) >= base && (LEN_W+1)'(i) < sum)
              hdr_d[8*i +: 8] = lane[2'((LEN_W+1)'(i) - base)];
          end
          if (sum > MAX_P) begin
            wr_ptr_d = MAX_P;
            trunc_d  = 1'b1;
            state_d  = s_last_i ? START : DRAIN;
          end else begin
            wr_ptr_d = sum;
            if (s_last_i) state_d = START;
          end
        end
      end
      DRAIN: begin
        if (xfer && cnt != 3'd0 && s_last_i) state_d = START;
      end
      START: begin
        if (!ready_i) state_d = RUN;
      end
      RUN: begin
        if (ready_i) begin
          state_d = FILL;
          first_d = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      hdr_q    <= '0;
      trunc_q  <= 1'b0;
      first_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      hdr_q    <= hdr_d;
      trunc_q  <= trunc_d;
      first_q  <= first_d;
    end
  end

  assign pkt_hdr_o = hdr_q;
  assign hdr_len_o = wr_ptr_q[LEN_W-1:0];
  assign trunc_o   = trunc_q;

`ifdef HDR_LOADER_STATS_EN
  logic [31:0] pkt_cnt_q, trunc_cnt_q;
  logic        to_start;

  assign to_start = (state_q == FILL || state_q == DRAIN) && state_d == START;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q   <= '0;
      trunc_cnt_q <= '0;
    end else if (to_start) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (trunc_d) trunc_cnt_q <= trunc_cnt_q + 32'd1;
    end
  end

  assign pkt_cnt_o   = pkt_cnt_q;
  assign trunc_cnt_o = trunc_cnt_q;
`endif

endmodule
